// File: rtl/aux_burst_seq.sv
// aux_burst_seq: splits one 1..16 byte DPCD command into single-byte AUX transactions with per-byte retry.
// Optional feature macro DPCD_TIMEOUT_EN: abort an attempt with no auxack/auxerr within TIMEOUT cycles.
module aux_burst_seq #(
  parameter int unsigned MAXRETRY = 7,
  parameter int unsigned GAPCYC   = 200,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdvalid,
  output logic        cmdready,
  input  logic [19:0] cmdaddr,
  input  logic [3:0]  cmdlen,
  input  logic        cmdwr,
  input  logic        bufwe,
  input  logic [3:0]  bufaddr,
  input  logic [7:0]  bufwdata,
  output logic [7:0]  bufrdata,
  output logic        done,
  output logic        err,
  output logic [4:0]  xfercnt,
  output logic [19:0] auxaddr,
  output logic [7:0]  auxwdata,
  output logic        auxwr,
  output logic        auxreq,
  input  logic        auxack,
  input  logic        auxerr,
  input  logic [7:0]  auxrdata
);

  localparam int unsigned RW = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;
  localparam int unsigned GW = $clog2(GAPCYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;
  state_t state, state_nx;

  logic [7:0]    buffer [16];
  logic [19:0]   addr;
  logic [3:0]    len;
  logic [3:0]    index;
  logic          wr;
  logic [RW-1:0] retry;
  logic [GW-1:0] gcnt;
  logic          tmo;
  logic          fail;
  logic          last_try;

`ifdef DPCD_TIMEOUT_EN
  logic [31:0] tcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == S_ISSUE) begin
      tcnt <= '0;
    end else if (state == S_WAIT) begin
      tcnt <= tcnt + 32'd1;
    end
  end

  // tcnt reaches TIMEOUT-1 on the edge that would complete TIMEOUT cycles of auxreq high
  assign tmo = (state == S_WAIT) && (tcnt == 32'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo = 1'b0;
`endif

  assign fail     = auxerr || (tmo && !auxack);
  assign last_try = (retry == RW'(MAXRETRY));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmdvalid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (fail) begin
          state_nx = last_try ? S_DONE : S_GAP;
        end else if (auxack) begin
          state_nx = (index == len) ? S_DONE : S_GAP;
        end
      end
      S_GAP:   if (gcnt == GW'(GAPCYC - 1)) state_nx = S_ISSUE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cmdready <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      xfercnt  <= '0;
      index    <= '0;
      retry    <= '0;
      gcnt     <= '0;
      addr     <= '0;
      len      <= '0;
      wr       <= 1'b0;
      auxaddr  <= '0;
      auxwdata <= '0;
      auxwr    <= 1'b0;
      auxreq   <= 1'b0;
    end else begin
      state    <= state_nx;
      cmdready <= (state_nx == S_IDLE);
      done     <= (state_nx == S_DONE);
      case (state)
        S_IDLE: begin
          if (cmdvalid) begin
            addr    <= cmdaddr;
            len     <= cmdlen;
            wr      <= cmdwr;
            index   <= '0;
            retry   <= '0;
            xfercnt <= '0;
            err     <= 1'b0;
          end
        end
        S_ISSUE: begin
          auxaddr  <= addr + {16'd0, index};
          auxwdata <= buffer[index];
          auxwr    <= wr;
          auxreq   <= 1'b1;
        end
        S_WAIT: begin
          if (fail) begin
            auxreq <= 1'b0;
            gcnt   <= '0;
            if (last_try) err <= 1'b1;
            else          retry <= retry + 1'b1;
          end else if (auxack) begin
            auxreq  <= 1'b0;
            gcnt    <= '0;
            xfercnt <= xfercnt + 5'd1;
            if (index != len) begin
              index <= index + 4'd1;
              retry <= '0;
            end
          end
        end
        S_GAP:   gcnt <= gcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Host port only writes while idle; read-back of a sink byte lands on its successful ack
  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE && bufwe) begin
      buffer[bufaddr] <= bufwdata;
    end else if (!reset && state == S_WAIT && auxack && !fail && !wr) begin
      buffer[index] <= auxrdata;
    end
    bufrdata <= buffer[bufaddr];
  end

endmodule

// File: tb/tb_aux_burst_seq.sv
// Scoreboard bench for aux_burst_seq: a behavioural command model predicts AUX transactions, results and buffer.
// Timeout scenario compiled in only with DPCD_TIMEOUT_EN.
module tb_aux_burst_seq;
  localparam int unsigned MAXRETRY = 7;
  localparam int unsigned GAPCYC   = 4;
  localparam int unsigned TIMEOUT  = 100;
  localparam int SILENT  = 254;
  localparam int PERSIST = 255;
`ifdef DPCD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, cmdvalid = 1'b0, cmdwr = 1'b0, bufwe = 1'b0;
  logic        auxack = 1'b0, auxerr = 1'b0;
  logic        cmdready, done, err, auxwr, auxreq;
  logic [19:0] cmdaddr = '0, auxaddr;
  logic [3:0]  cmdlen = '0, bufaddr = '0;
  logic [7:0]  bufwdata = '0, bufrdata, auxwdata, auxrdata = '0;
  logic [4:0]  xfercnt;

  aux_burst_seq #(.MAXRETRY(MAXRETRY), .GAPCYC(GAPCYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmdvalid(cmdvalid), .cmdready(cmdready), .cmdaddr(cmdaddr),
    .cmdlen(cmdlen), .cmdwr(cmdwr), .bufwe(bufwe), .bufaddr(bufaddr), .bufwdata(bufwdata),
    .bufrdata(bufrdata), .done(done), .err(err), .xfercnt(xfercnt), .auxaddr(auxaddr),
    .auxwdata(auxwdata), .auxwr(auxwr), .auxreq(auxreq), .auxack(auxack), .auxerr(auxerr),
    .auxrdata(auxrdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [19:0] addr; logic [7:0] data; logic wr; } txn_t;
  typedef struct { logic err; logic [4:0] xfer; } res_t;

  txn_t        exp_txn [$];
  res_t        exp_res [$];
  logic [7:0]  mbuf [16];
  int          fail_plan [16];
  int          att [16];
  logic [19:0] cur_addr = '0;
  int          errmode = 0;
  int          tests = 0, fails = 0;
  int          cyc = 0, rise_cnt = 0, done_cnt = 0;
  bit          gap_valid = 1'b0;
  int          expect_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) fail_plan[i] = 0;
  endtask

  // Reference: each byte takes (failures+1) attempts, capped at MAXRETRY+1 which aborts the command
  task automatic run_model(input logic [19:0] a, input int len, input logic wr);
    int completed = 0;
    bit abort = 1'b0;
    bit hang = 1'b0;
    for (int i = 0; i <= len && !abort && !hang; i++) begin
      int f = fail_plan[i];
      int tries;
      logic [19:0] ba;
      ba = a + 20'(i);
      if (f == SILENT && TMO_EN) f = PERSIST;
      if (f == SILENT) begin
        exp_txn.push_back('{ba, mbuf[i], wr});
        hang = 1'b1;
      end else begin
        tries = (f > int'(MAXRETRY)) ? int'(MAXRETRY) + 1 : f + 1;
        repeat (tries) exp_txn.push_back('{ba, mbuf[i], wr});
        if (f > int'(MAXRETRY)) begin
          abort = 1'b1;
        end else begin
          if (!wr) mbuf[i] = ba[7:0] ^ 8'h5A;
          completed++;
        end
      end
    end
    if (!hang) exp_res.push_back('{abort, 5'(completed)});
  endtask

  task automatic host_write(input logic [3:0] idx, input logic [7:0] data);
    bufwe = 1'b1; bufaddr = idx; bufwdata = data;
    @(posedge clk); #1;
    bufwe = 1'b0;
    mbuf[idx] = data;
  endtask

  task automatic check_buf();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bufaddr = 4'(i);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("buf[%0d]", i), {24'd0, bufrdata}, {24'd0, mbuf[i]});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_cmd(input logic [19:0] a, input logic [3:0] len, input logic wr,
                        input bit pre_we, input logic [3:0] pidx, input logic [7:0] pdata,
                        input bit wait_done);
    int start_done;
    int budget = 0;
    while (!cmdready && budget < 100) begin @(posedge clk); #1; budget++; end
    if (!cmdready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: cmdready=%0b after %0d cycles, required 1", cmdready, budget);
    end
    cur_addr = a; gap_valid = 1'b0;
    for (int i = 0; i < 16; i++) att[i] = 0;
    cmdaddr = a; cmdlen = len; cmdwr = wr; cmdvalid = 1'b1;
    if (pre_we) begin
      bufwe = 1'b1; bufaddr = pidx; bufwdata = pdata;
      mbuf[pidx] = pdata;
    end
    run_model(a, int'(len), wr);
    start_done = done_cnt;
    @(posedge clk); #1;
    cmdvalid = 1'b0;
    // host writes while busy must be dropped
    repeat (2) begin
      bufwe = 1'b1; bufaddr = 4'($urandom); bufwdata = 8'($urandom);
      @(posedge clk); #1;
    end
    bufwe = 1'b0;
    if (wait_done) begin
      budget = 0;
      while (done_cnt == start_done && budget < 20000) begin @(posedge clk); #1; budget++; end
      if (done_cnt == start_done) begin
        tests++; fails++;
        $display("FAIL done_timeout: no done within %0d cycles for addr 0x%0h", budget, a);
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        exp_txn.delete(); exp_res.delete();
      end
    end
  endtask

  initial begin : monitor
    logic prev_req;
    int   t_rise, t_fall;
    txn_t e;
    res_t r;
    prev_req = 1'b0; t_rise = 0; t_fall = 0;
    forever begin
      @(negedge clk);
      if (auxreq && !prev_req) begin
        rise_cnt++;
        t_rise = cyc;
        if (gap_valid) begin
          tests++;
          if (cyc - t_fall < int'(GAPCYC)) begin
            fails++;
            $display("FAIL gap_low: got %0d low cycles, required >= %0d", cyc - t_fall, GAPCYC);
          end
        end
        if (exp_txn.size() == 0) begin
          tests++; fails++;
          $display("FAIL txn_unexp: got request addr 0x%0h, required none", auxaddr);
        end else begin
          e = exp_txn.pop_front();
          check("txn_addr", {12'd0, auxaddr}, {12'd0, e.addr});
          check("txn_wdata", {24'd0, auxwdata}, {24'd0, e.data});
          check("txn_wr", {31'd0, auxwr}, {31'd0, e.wr});
        end
      end
      if (!auxreq && prev_req) begin
        t_fall = cyc;
        gap_valid = 1'b1;
        if (expect_hi != 0) check("hi_cycles", cyc - t_rise, expect_hi);
      end
      if (done) begin
        done_cnt++;
        if (exp_res.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexp: got done err=%0b xfercnt=%0d, required none", err, xfercnt);
        end else begin
          r = exp_res.pop_front();
          check("done_err", {31'd0, err}, {31'd0, r.err});
          check("done_xfercnt", {27'd0, xfercnt}, {27'd0, r.xfer});
          check("txn_left", exp_txn.size(), 0);
        end
      end
      prev_req = auxreq;
    end
  end

  // Transceiver model: answers each request per fail_plan, plus spurious pulses while auxreq is low
  initial begin : responder
    logic        prev;
    bit          pending;
    int          dly, kind, idx;
    logic [19:0] d;
    prev = 1'b0; pending = 1'b0; dly = 0; kind = 0;
    forever begin
      @(negedge clk);
      auxack = 1'b0; auxerr = 1'b0;
      if (!reset && auxreq && !prev) begin
        d = auxaddr - cur_addr;
        idx = int'(d[3:0]);
        if (fail_plan[idx] == SILENT) kind = 3;
        else if (fail_plan[idx] == PERSIST || att[idx] < fail_plan[idx]) kind = 1;
        else kind = 0;
        att[idx]++;
        if (kind == 1 && (errmode == 1 || (errmode == 2 && $urandom_range(0, 1) == 1))) kind = 2;
        dly = $urandom_range(0, 3);
        pending = (kind != 3);
      end
      if (reset || !auxreq) pending = 1'b0;
      if (pending) begin
        if (dly == 0) begin
          auxack = (kind != 1);
          auxerr = (kind != 0);
          auxrdata = auxaddr[7:0] ^ 8'h5A;
          pending = 1'b0;
        end else begin
          dly--;
        end
      end else if (!reset && !auxreq && $urandom_range(0, 7) == 0) begin
        auxack = 1'b1;
        auxerr = 1'($urandom_range(0, 1));
        auxrdata = 8'($urandom);
      end
      prev = auxreq;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0, d0, budget;
    clear_plan();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmdready", {31'd0, cmdready}, 1);
    check("rst_auxreq", {31'd0, auxreq}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_xfercnt", {27'd0, xfercnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) host_write(4'(i), 8'($urandom));

    host_write(4'd0, 8'hA1); host_write(4'd1, 8'hB2); host_write(4'd2, 8'hC3);
    do_cmd(20'h00100, 4'd2, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1);
    check("xfer_hold", {27'd0, xfercnt}, 3);
    check_buf();

    do_cmd(20'h00000, 4'd15, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    check_buf();

    clear_plan(); fail_plan[0] = 2; errmode = 1;
    do_cmd(20'h00202, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    errmode = 2;
    check_buf();

    clear_plan(); fail_plan[1] = PERSIST;
    do_cmd(20'h00400, 4'd3, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    check("err_hold", {31'd0, err}, 1);
    check_buf();

    clear_plan();
    do_cmd(20'hFFFFF, 4'd1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    check_buf();

    do_cmd(20'h12345, 4'd0, 1'b1, 1'b1, 4'd0, 8'h77, 1'b1);

    for (int n = 0; n < 12; n++) begin
      int rv;
      for (int i = 0; i < 16; i++) begin
        rv = $urandom_range(0, 15);
        fail_plan[i] = (rv < 10) ? 0 : (rv < 14) ? rv - 9 : (rv == 14) ? PERSIST : 0;
      end
      do_cmd(20'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1'b1);
      check_buf();
    end

    clear_plan(); fail_plan[1] = SILENT;
    r0 = rise_cnt;
    do_cmd(20'h00300, 4'd3, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    budget = 0;
    while (rise_cnt < r0 + 2 && budget < 500) begin @(posedge clk); #1; budget++; end
    check("rst_test_rises", rise_cnt - r0, 2);
    repeat (3) begin @(posedge clk); #1; end
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_auxreq", {31'd0, auxreq}, 0);
    check("midrst_cmdready", {31'd0, cmdready}, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_txn.delete(); exp_res.delete();
    repeat (10) begin @(posedge clk); #1; end
    check("midrst_no_done", done_cnt, d0);
    check_buf();
    clear_plan();
    do_cmd(20'h00310, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    check_buf();

`ifdef DPCD_TIMEOUT_EN
    clear_plan(); fail_plan[0] = SILENT; expect_hi = int'(TIMEOUT);
    do_cmd(20'h00500, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    expect_hi = 0;
    check("tmo_err", {31'd0, err}, 1);
    clear_plan();
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
